axi_ram_backend: RTL
====================

# axi_ram_backend

Single-port, byte-writable RAM backend that consumes the unified RAM command stream produced by the AXI RAM read/write arbiter and returns read data on the RAM read-response stream. It sits directly downstream of that arbiter and is the storage element of the AXI RAM. A credit-limited response FIFO absorbs `ram_rd_resp_ready` backpressure, so no read data is ever dropped.

## Interface
- `DATA_WIDTH`, 32: data bus width in bits; a multiple of 8.
- `ADDR_WIDTH`, 16: byte address width.
- `STRB_WIDTH`, DATA_WIDTH/8: byte-strobe width.
- `ID_WIDTH`, 8: transaction ID width.
- `AUSER_WIDTH`, 1: command user width; the block ignores this field.
- `WUSER_WIDTH`, 1: write user width; the block ignores this field.
- `RUSER_WIDTH`, 1: read-response user width.
- `PIPELINE_OUTPUT`, 0: 1 adds one output register stage to read latency.
- `RESP_FIFO_DEPTH`, 4: maximum outstanding reads; must be at least 2 + PIPELINE_OUTPUT.

Ports:
- `clk`, in, 1: clock; all logic is rising-edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `ram_cmd_id`, in, ID_WIDTH: command ID.
- `ram_cmd_addr`, in, ADDR_WIDTH: byte address.
- `ram_cmd_lock`, `ram_cmd_cache`, `ram_cmd_prot`, `ram_cmd_qos`, `ram_cmd_region`, in, 1/4/3/4/4: accepted and ignored.
- `ram_cmd_auser`, in, AUSER_WIDTH: accepted and ignored.
- `ram_cmd_wr_data`, in, DATA_WIDTH: write data.
- `ram_cmd_wr_strb`, in, STRB_WIDTH: byte enables.
- `ram_cmd_wr_user`, in, WUSER_WIDTH: accepted and ignored.
- `ram_cmd_wr_en`, in, 1: write command valid.
- `ram_cmd_rd_en`, in, 1: read command valid.
- `ram_cmd_last`, in, 1: last beat of burst; forwarded on reads.
- `ram_cmd_ready`, out, 1: command accept.
- `ram_rd_resp_id`, out, ID_WIDTH: read-response ID.
- `ram_rd_resp_data`, out, DATA_WIDTH: read-response data.
- `ram_rd_resp_last`, out, 1: read-response last beat.
- `ram_rd_resp_user`, out, RUSER_WIDTH: driven all-zero.
- `ram_rd_resp_valid`, out, 1: read-response valid.
- `ram_rd_resp_ready`, in, 1: read-response accept.

## Operation
- **Array.** 2^(ADDR_WIDTH−clog2(STRB_WIDTH)) words of DATA_WIDTH bits. The word index is `addr[ADDR_WIDTH-1:clog2(STRB_WIDTH)]`; low address bits are ignored.
- **Write.** A write executes on an edge where `ram_cmd_wr_en && ram_cmd_ready`. Byte i is written only when `wr_strb[i]=1`. A write produces no response.
- **Read.** A read executes on an edge where `ram_cmd_rd_en && ram_cmd_ready`. The array is read synchronously, and id and last are carried alongside the data.
- **Both enables high.** `ram_cmd_wr_en && ram_cmd_rd_en` is a protocol violation. The block performs only the read.
- **Credit counter.** `outstanding` counts reads that have been accepted but not yet handed off (`resp_valid && resp_ready`). Width is clog2(RESP_FIFO_DEPTH+1).
  - `ram_cmd_ready = (outstanding < RESP_FIFO_DEPTH)`. It is registered-path only and never depends combinationally on `ram_cmd_*_en`.
  - When an accept and a hand-off happen on the same edge, `outstanding` is unchanged.
- **Response order.** Responses return strictly in command order. When the FIFO is empty and the data has arrived, the response is presented directly (bypass). If it is not accepted, it is captured into the FIFO. Nothing is lost while `ram_cmd_ready` gates intake.
- **Memory contents.** The array is not reset.

## Timing
- **Reset values.** `ram_cmd_ready=1`, `ram_rd_resp_valid=0`, and `id`/`data`/`last`/`user` are 0. `outstanding=0` and the FIFO is empty.
- **Reset mid-burst.** In-flight reads are discarded and the FIFO pointers clear. Array contents persist.
- **Read latency.** A read accepted on edge E0 gives `ram_rd_resp_valid=1` in the cycle after E0 when PIPELINE_OUTPUT=0, and one cycle later when it is 1. The FIFO must be empty for this.
- **Throughput.** With `resp_ready` held high, the block sustains one read per cycle.
- **Read-after-write.** A write on edge E0 followed by a read of the same word on E1 returns the new data.
- **Response handshake.** Once `ram_rd_resp_valid` is asserted, it and all payload fields hold stable until `ram_rd_resp_ready`.
- **FIFO full.** When the FIFO is full, `ram_cmd_ready` drops in the cycle after the accept that brings `outstanding` to RESP_FIFO_DEPTH. It rises in the cycle after the first hand-off.
- **Write/read mix.** Writes are also stalled while `ram_cmd_ready=0`.

## Structure
- Shared package / common include: a `clog2` function and the zero `RUSER` constant.
- One sub-module, `axi_ram_resp_fifo`. It is a synchronous FIFO of `{id, last, data}` with depth RESP_FIFO_DEPTH, an asynchronous active-low reset, and full/empty/count outputs.
- The top level holds the array, the read-stage registers, the optional pipeline register, the credit counter and the bypass mux.

## Test plan
- Reset → `ram_cmd_ready=1`, `ram_rd_resp_valid=0`; assert `rst_n` low mid-burst → valid drops immediately and `outstanding` clears.
- Write 0xDEADBEEF to addr 0x10 with strb 0xF, then write 0x000000AA with strb 0x1, then read addr 0x10 with id 3 → data 0xDEADBEAA, id 3, last 1, at latency 1 (PIPELINE_OUTPUT=0) and latency 2 (PIPELINE_OUTPUT=1).
- Eight back-to-back reads with `resp_ready=1` → one response per cycle, in order, with ready never dropping.
- Hold `resp_ready=0` and issue reads → exactly RESP_FIFO_DEPTH (4) accepted, then ready low. Release → four responses in order, and ready returns the cycle after the first hand-off.
- Write then read the same word on consecutive edges → new data returned. Drive `wr_en` and `rd_en` together → the read is performed and the array is unchanged.
- Random 10k mixed traffic with random backpressure against a scoreboard model → zero mismatches and no response lost or duplicated.

Source files
------------

// File: rtl/axi_ram_backend_pkg.sv
// Shared helpers for the AXI RAM backend: a constant-evaluable clog2 and the
// zero value driven on the read-response user field.
package axi_ram_backend_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    localparam logic RUSER_ZERO_BIT = 1'b0;

endpackage

// File: rtl/axi_ram_resp_fifo.sv
// Synchronous FIFO holding {id, last, data} read responses that could not be
// handed off in the cycle their data arrived.
module axi_ram_resp_fifo
    import axi_ram_backend_pkg::*;
#(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4,
    localparam int PTR_W = clog2(DEPTH),
    localparam int CNT_W = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign count    = count_q;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = storage[rd_ptr];

    // Pointers wrap explicitly so non-power-of-two depths work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/axi_ram_backend.sv
// Byte-writable single-port RAM behind the AXI RAM arbiter; read responses
// return in order, with a credit-limited FIFO absorbing response backpressure.
module axi_ram_backend
    import axi_ram_backend_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 16,
    parameter int STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int ID_WIDTH        = 8,
    parameter int AUSER_WIDTH     = 1,
    parameter int WUSER_WIDTH     = 1,
    parameter int RUSER_WIDTH     = 1,
    parameter int PIPELINE_OUTPUT = 0,
    parameter int RESP_FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ID_WIDTH-1:0]    ram_cmd_id,
    input  logic [ADDR_WIDTH-1:0]  ram_cmd_addr,
    input  logic                   ram_cmd_lock,
    input  logic [3:0]             ram_cmd_cache,
    input  logic [2:0]             ram_cmd_prot,
    input  logic [3:0]             ram_cmd_qos,
    input  logic [3:0]             ram_cmd_region,
    input  logic [AUSER_WIDTH-1:0] ram_cmd_auser,
    input  logic [DATA_WIDTH-1:0]  ram_cmd_wr_data,
    input  logic [STRB_WIDTH-1:0]  ram_cmd_wr_strb,
    input  logic [WUSER_WIDTH-1:0] ram_cmd_wr_user,
    input  logic                   ram_cmd_wr_en,
    input  logic                   ram_cmd_rd_en,
    input  logic                   ram_cmd_last,
    output logic                   ram_cmd_ready,
    output logic [ID_WIDTH-1:0]    ram_rd_resp_id,
    output logic [DATA_WIDTH-1:0]  ram_rd_resp_data,
    output logic                   ram_rd_resp_last,
    output logic [RUSER_WIDTH-1:0] ram_rd_resp_user,
    output logic                   ram_rd_resp_valid,
    input  logic                   ram_rd_resp_ready
);

    localparam int WORD_LSB = clog2(STRB_WIDTH);
    localparam int WORD_W   = ADDR_WIDTH - WORD_LSB;
    localparam int WORDS    = 1 << WORD_W;
    localparam int CNT_W    = clog2(RESP_FIFO_DEPTH + 1);
    localparam int FCNT_W   = clog2(RESP_FIFO_DEPTH + 1);
    localparam int ENTRY_W  = ID_WIDTH + 1 + DATA_WIDTH;
    localparam logic [CNT_W-1:0] MAX_OUT = CNT_W'(RESP_FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [WORDS];

    logic [WORD_W-1:0]     word_idx;
    logic                  rd_fire;
    logic                  wr_fire;
    logic                  handoff;
    logic [CNT_W-1:0]      outstanding;

    logic                  rd_valid_q;
    logic [ID_WIDTH-1:0]   rd_id_q;
    logic                  rd_last_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic                  s_valid;
    logic [ENTRY_W-1:0]    s_entry;
    logic [ENTRY_W-1:0]    out_entry;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic [ENTRY_W-1:0]    fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FCNT_W-1:0]     fifo_count;

    assign word_idx      = ram_cmd_addr[ADDR_WIDTH-1:WORD_LSB];
    assign ram_cmd_ready = (outstanding < MAX_OUT);
    assign rd_fire       = ram_cmd_rd_en && ram_cmd_ready;
    // A simultaneous write+read is a protocol violation; only the read is honoured.
    assign wr_fire       = ram_cmd_wr_en && !ram_cmd_rd_en && ram_cmd_ready;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (ram_cmd_wr_strb[i]) begin
                    mem[word_idx][i*8 +: 8] <= ram_cmd_wr_data[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_id_q    <= '0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                rd_id_q   <= ram_cmd_id;
                rd_last_q <= ram_cmd_last;
                rd_data_q <= mem[word_idx];
            end
        end
    end

    if (PIPELINE_OUTPUT != 0) begin : g_pipe
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_valid <= 1'b0;
                s_entry <= '0;
            end else begin
                s_valid <= rd_valid_q;
                if (rd_valid_q) begin
                    s_entry <= {rd_id_q, rd_last_q, rd_data_q};
                end
            end
        end
    end else begin : g_no_pipe
        assign s_valid = rd_valid_q;
        assign s_entry = {rd_id_q, rd_last_q, rd_data_q};
    end

    // Stage data lives for one cycle only: anything not taken straight through
    // the bypass is parked in the FIFO so it can be held stable.
    assign fifo_push = s_valid && !(fifo_empty && ram_rd_resp_ready);
    assign fifo_pop  = !fifo_empty && ram_rd_resp_ready;

    axi_ram_resp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (RESP_FIFO_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (s_entry),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_entry         = fifo_empty ? s_entry : fifo_head;
    assign ram_rd_resp_valid = fifo_empty ? s_valid : 1'b1;
    assign {ram_rd_resp_id, ram_rd_resp_last, ram_rd_resp_data} = out_entry;
    assign ram_rd_resp_user  = {RUSER_WIDTH{RUSER_ZERO_BIT}};
    assign handoff           = ram_rd_resp_valid && ram_rd_resp_ready;

    // Credits: every accepted read holds one until its response is handed off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            case ({rd_fire, handoff})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = ^{ram_cmd_lock, ram_cmd_cache, ram_cmd_prot, ram_cmd_qos,
                         ram_cmd_region, ram_cmd_auser, ram_cmd_wr_user,
                         ram_cmd_addr, fifo_full, fifo_count};

endmodule
